uart_tx_fifo: RTL

//  Parametrised UART transmitter, successor to the fixed 8N1 tx. Adds configurable

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_sync_fifo.sv | 39 +++
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, frame-length helper and tx FSM encoding
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_t;
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO; a write while full is taken when a read frees the slot
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_we, w_re;
  assign w_re  = rd && !empty;
  assign w_we  = wr && (!full || w_re);
  assign rdata = r_mem[r_rp];
  assign full  = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign count = r_cnt;
  always_ff @(posedge clk)
    if (w_we) r_mem[r_wp] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_we);
      r_rp  <= r_rp + AW'(w_re);
      r_cnt <= r_cnt + (AW+1)'(w_we) - (AW+1)'(w_re);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by an input FIFO
// Frames go out back-to-back whenever the FIFO holds data at the end of a stop bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bclk,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_rdy,
  output logic                          txd,
  output logic                          tx_rdy,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          overflow
);
  localparam int CW = $clog2(DATA_BITS);
  tx_state_t            r_state, w_state_n;
  logic [DATA_BITS-1:0] r_sh, w_sh_n, w_rdata;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic                 r_stop, w_stop_n, r_par, w_par_n, r_txd, w_txd_n, r_ovf;
  logic                 w_pop, w_full, w_empty, w_stop_last;
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 ||
      STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter combination");
  end
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .clk(clk), .rst(rst), .wr(din_rdy), .wdata(din), .rd(w_pop),
    .rdata(w_rdata), .full(w_full), .empty(w_empty), .count(fifo_cnt)
  );
  assign w_stop_last = r_stop == 1'(STOP_BITS - 1);
  assign w_pop = bclk && !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_stop_last));
  always_comb begin
    w_state_n = r_state;
    w_sh_n    = r_sh;
    w_cnt_n   = r_cnt;
    w_stop_n  = r_stop;
    w_par_n   = r_par;
    w_txd_n   = r_txd;
    if (bclk)
      case (r_state)
        S_IDLE: begin
          w_txd_n   = !w_pop;
          w_state_n = w_pop ? S_START : S_IDLE;
        end
        S_START: begin
          w_txd_n   = r_sh[0];
          w_sh_n    = r_sh >> 1;
          w_cnt_n   = '0;
          w_state_n = S_DATA;
        end
        S_DATA:
          if (r_cnt == CW'(DATA_BITS - 1)) begin
            w_txd_n   = (PARITY != PARITY_NONE) ? r_par : 1'b1;
            w_stop_n  = 1'b0;
            w_state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
          end else begin
            w_txd_n = r_sh[0];
            w_sh_n  = r_sh >> 1;
            w_cnt_n = r_cnt + CW'(1);
          end
        S_PARITY: begin
          w_txd_n   = 1'b1;
          w_stop_n  = 1'b0;
          w_state_n = S_STOP;
        end
        S_STOP:
          if (w_stop_last) begin
            w_txd_n   = !w_pop;
            w_state_n = w_pop ? S_START : S_IDLE;
          end else
            w_stop_n = 1'b1;
        default: w_state_n = S_IDLE;
      endcase
    if (w_pop) begin
      w_sh_n  = w_rdata;
      w_par_n = ^w_rdata ^ (PARITY == PARITY_ODD);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_stop  <= 1'b0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sh    <= w_sh_n;
      r_cnt   <= w_cnt_n;
      r_stop  <= w_stop_n;
      r_par   <= w_par_n;
      r_txd   <= w_txd_n;
      r_ovf   <= r_ovf | (din_rdy && w_full && !w_pop);
    end
  assign txd      = r_txd;
  assign tx_rdy   = !w_full;
  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign overflow = r_ovf;
endmodule
